branch_resolve_ctrl: RTL and testbench



---
 rtl/branch_pkg.sv | 27 ++
 rtl/bp_rec_fifo.sv | 54 +++++
 rtl/branch_resolve_ctrl.sv | 117 +++++++++++
 tb/tb_branch_resolve_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and defaults for the branch resolution sequencer and its record queue.
package branch_pkg;

  localparam int DEFAULT_DEPTH        = 4;
  localparam int DEFAULT_FLUSH_CYCLES = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } bp_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] target;
  } bp_rec_t;

  // A taken branch is only correct if the predicted target also matches.
  function automatic logic is_mispredict(bp_rec_t rec, logic taken, logic [31:0] target);
    return (taken != rec.pred) || (taken && (target != rec.target));
  endfunction

  function automatic logic [31:0] correct_pc(bp_rec_t rec, logic taken, logic [31:0] target);
    return taken ? target : rec.pc + 32'd4;
  endfunction

endpackage

// File: rtl/bp_rec_fifo.sv
// Circular buffer of in-flight branch records; clear empties it in one cycle.
module bp_rec_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  bp_rec_t                  push_rec,
  input  logic                     pop,
  input  logic                     clear,
  output bp_rec_t                  head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  bp_rec_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_en;
  logic            pop_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push && !full && !clear;
  assign pop_en  = pop && !empty && !clear;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_rec;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// In-order branch resolution: predictor update strobe, mispredict flush/redirect, statistics.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  input  logic        f_pred,
  input  logic [31:0] f_target,
  output logic        f_ready,
  input  logic        r_valid,
  input  logic        r_taken,
  input  logic [31:0] r_target,
  output logic        upd_valid,
  output logic        upd_taken,
  output logic [31:0] upd_pc,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] mispredict_cnt,
  output logic [31:0] branch_cnt,
  output logic        err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  bp_state_t       state;
  logic [FW-1:0]   flush_left;
  bp_rec_t         head;
  bp_rec_t         new_rec;
  logic [CW-1:0]   rec_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            idle;
  logic            accept;
  logic            resolve;
  logic            empty_resolve;
  logic            mispredict;

  // Handshake: a record transfers on a cycle where f_valid && f_ready; a resolve
  // has no back-pressure and is honoured only in IDLE with a non-empty queue.
  assign idle          = (state == IDLE);
  assign f_ready       = idle && !fifo_full;
  assign accept        = f_valid && f_ready;
  assign resolve       = r_valid && idle && (rec_count != '0);
  assign empty_resolve = r_valid && idle && fifo_empty;
  assign mispredict    = resolve && is_mispredict(head, r_taken, r_target);
  assign new_rec       = '{pc: f_pc, pred: f_pred, target: f_target};

  // A push that coincides with a mispredict is wrong-path and is dropped by the clear.
  bp_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (accept),
    .push_rec (new_rec),
    .pop      (resolve && !mispredict),
    .clear    (mispredict),
    .head     (head),
    .count    (rec_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      flush_left     <= '0;
      upd_valid      <= 1'b0;
      upd_taken      <= 1'b0;
      upd_pc         <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mispredict_cnt <= '0;
      branch_cnt     <= '0;
      err            <= 1'b0;
    end else begin
      upd_valid      <= 1'b0;
      redirect_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (empty_resolve) err <= 1'b1;
          if (resolve) begin
            upd_valid <= 1'b1;
            upd_taken <= r_taken;
            upd_pc    <= head.pc;
            if (branch_cnt != '1) branch_cnt <= branch_cnt + 32'd1;
            if (mispredict) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= correct_pc(head, r_taken, r_target);
              if (mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + 32'd1;
              state      <= FLUSH;
              flush      <= 1'b1;
              flush_left <= FW'(FLUSH_CYCLES);
            end
          end
        end
        FLUSH: begin
          if (flush_left == FW'(1)) begin
            state      <= IDLE;
            flush      <= 1'b0;
            flush_left <= '0;
          end else begin
            flush_left <= flush_left - FW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed vector bench for branch_resolve_ctrl, plus a reset-during-flush sequence.
module tb_branch_resolve_ctrl;
  import branch_pkg::*;

  logic        clk;
  logic        rstn;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        f_pred;
  logic [31:0] f_target;
  logic        f_ready;
  logic        r_valid;
  logic        r_taken;
  logic [31:0] r_target;
  logic        upd_valid;
  logic        upd_taken;
  logic [31:0] upd_pc;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mispredict_cnt;
  logic [31:0] branch_cnt;
  logic        err;

  int tests;
  int fails;

  logic [31:0] exp_q[$];

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic        fpred;
    logic [31:0] ftgt;
    logic        rv;
    logic        rtk;
    logic [31:0] rtgt;
    logic        e_fr;
    logic        e_uv;
    logic        e_ut;
    logic [31:0] e_upc;
    logic        e_fl;
    logic        e_rdv;
    logic [31:0] e_rdpc;
    logic [31:0] e_mc;
    logic [31:0] e_bc;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  branch_resolve_ctrl #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .f_pred         (f_pred),
    .f_target       (f_target),
    .f_ready        (f_ready),
    .r_valid        (r_valid),
    .r_taken        (r_taken),
    .r_target       (r_target),
    .upd_valid      (upd_valid),
    .upd_taken      (upd_taken),
    .upd_pc         (upd_pc),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mispredict_cnt (mispredict_cnt),
    .branch_cnt     (branch_cnt),
    .err            (err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic fv, logic [31:0] fpc, logic fpred, logic [31:0] ftgt,
                              logic rv, logic rtk, logic [31:0] rtgt, logic e_fr,
                              logic e_uv, logic e_ut, logic [31:0] e_upc, logic e_fl,
                              logic e_rdv, logic [31:0] e_rdpc, logic [31:0] e_mc,
                              logic [31:0] e_bc, logic e_err);
    vec_t v;
    v.fv = fv; v.fpc = fpc; v.fpred = fpred; v.ftgt = ftgt;
    v.rv = rv; v.rtk = rtk; v.rtgt = rtgt; v.e_fr = e_fr;
    v.e_uv = e_uv; v.e_ut = e_ut; v.e_upc = e_upc; v.e_fl = e_fl;
    v.e_rdv = e_rdv; v.e_rdpc = e_rdpc; v.e_mc = e_mc; v.e_bc = e_bc; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver
  task automatic drive(input logic fv, input logic [31:0] fpc, input logic fpred,
                       input logic [31:0] ftgt, input logic rv, input logic rtk,
                       input logic [31:0] rtgt);
    f_valid = fv; f_pc = fpc; f_pred = fpred; f_target = ftgt;
    r_valid = rv; r_taken = rtk; r_target = rtgt;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rstn  = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Correct prediction
    vecs.push_back(mk(1,'h100,1,'h140, 0,0,0,       1, 0,0,0,      0, 0,0,       0,0,0));
    vecs.push_back(mk(0,0,0,0,         1,1,'h140,   1, 1,1,'h100,  0, 0,0,       0,1,0));
    // Direction mispredict and its two flush cycles
    vecs.push_back(mk(1,'h200,1,'h240, 0,0,0,       1, 0,0,0,      0, 0,0,       0,1,0));
    vecs.push_back(mk(0,0,0,0,         1,0,0,       1, 1,0,'h200,  1, 1,'h204,   1,2,0));
    vecs.push_back(mk(0,0,0,0,         0,0,0,       0, 0,0,0,      1, 0,0,       1,2,0));
    vecs.push_back(mk(0,0,0,0,         0,0,0,       0, 0,0,0,      0, 0,0,       1,2,0));
    vecs.push_back(mk(0,0,0,0,         0,0,0,       1, 0,0,0,      0, 0,0,       1,2,0));
    // Target mispredict with a same-cycle wrong-path push, then inputs during flush
    vecs.push_back(mk(1,'h300,1,'h340, 0,0,0,       1, 0,0,0,      0, 0,0,       1,2,0));
    vecs.push_back(mk(1,'h340,0,0,     0,0,0,       1, 0,0,0,      0, 0,0,       1,2,0));
    vecs.push_back(mk(1,'h500,1,'h540, 1,1,'h380,   1, 1,1,'h300,  1, 1,'h380,   2,3,0));
    vecs.push_back(mk(1,'h600,1,'h640, 1,1,'h640,   0, 0,0,0,      1, 0,0,       2,3,0));
    vecs.push_back(mk(0,0,0,0,         0,0,0,       0, 0,0,0,      0, 0,0,       2,3,0));
    // Queue must be empty now: resolve sets sticky err
    vecs.push_back(mk(0,0,0,0,         1,1,'h40,    1, 0,0,0,      0, 0,0,       2,3,1));
    vecs.push_back(mk(0,0,0,0,         0,0,0,       1, 0,0,0,      0, 0,0,       2,3,1));
    // Fill to DEPTH
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1,32'h1000 + 32'(k*16),0,0, 0,0,0, 1, 0,0,0, 0, 0,0, 2,3,1));
    // Full: push refused, resolve still pops
    vecs.push_back(mk(1,'h1040,0,0,    1,0,'hdead_beef, 0, 1,0,'h1000, 0, 0,0, 2,4,1));
    // Push and resolve together; pointers wrap
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(1,32'h1040 + 32'(k*16),0,0, 1,0,'hdead_beef, 1,
                        1,0,32'h1010 + 32'(k*16), 0, 0,0, 2,32'(5+k),1));
    vecs.push_back(mk(1,'h10a0,0,0,    0,0,0,       1, 0,0,0,      0, 0,0,       2,10,1));
    vecs.push_back(mk(0,0,0,0,         0,0,0,       0, 0,0,0,      0, 0,0,       2,10,1));
    // Mispredict from a full queue, ending in the first flush cycle
    vecs.push_back(mk(0,0,0,0,         1,1,'h2000,  0, 1,1,'h1070, 1, 1,'h2000,  3,11,1));
    vecs.push_back(mk(0,0,0,0,         0,0,0,       0, 0,0,0,      1, 0,0,       3,11,1));

    foreach (vecs[i]) if (vecs[i].e_uv) exp_q.push_back(vecs[i].e_upc);

    repeat (2) @(negedge clk);
    check("rst_f_ready", 32'(f_ready), 1);
    check("rst_upd_valid", 32'(upd_valid), 0);
    check("rst_flush", 32'(flush), 0);
    check("rst_branch_cnt", branch_cnt, 0);
    check("rst_err", 32'(err), 0);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].fv, vecs[i].fpc, vecs[i].fpred, vecs[i].ftgt,
            vecs[i].rv, vecs[i].rtk, vecs[i].rtgt);
      #1;
      check($sformatf("s%0d_f_ready", i), 32'(f_ready), 32'(vecs[i].e_fr));
      @(posedge clk);
      #1;
      check($sformatf("s%0d_upd_valid", i), 32'(upd_valid), 32'(vecs[i].e_uv));
      if (vecs[i].e_uv) begin
        check($sformatf("s%0d_upd_taken", i), 32'(upd_taken), 32'(vecs[i].e_ut));
        check($sformatf("s%0d_upd_pc", i), upd_pc, vecs[i].e_upc);
      end
      check($sformatf("s%0d_flush", i), 32'(flush), 32'(vecs[i].e_fl));
      check($sformatf("s%0d_redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].e_rdv));
      if (vecs[i].e_rdv)
        check($sformatf("s%0d_redirect_pc", i), redirect_pc, vecs[i].e_rdpc);
      check($sformatf("s%0d_mispredict_cnt", i), mispredict_cnt, vecs[i].e_mc);
      check($sformatf("s%0d_branch_cnt", i), branch_cnt, vecs[i].e_bc);
      check($sformatf("s%0d_err", i), 32'(err), 32'(vecs[i].e_err));
      // Scoreboard: every update pulse must match the next expected pc in order
      if (upd_valid) begin
        if (exp_q.size() == 0) check($sformatf("s%0d_sb_extra_upd", i), 32'(upd_valid), 0);
        else check($sformatf("s%0d_sb_upd_pc", i), upd_pc, exp_q.pop_front());
      end
    end
    check("sb_drained", 32'(exp_q.size()), 0);

    // Reset asserted in the second flush cycle
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("flush2_before_rst", 32'(flush), 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_flush", 32'(flush), 0);
    check("mid_rst_upd_pc", upd_pc, 0);
    check("mid_rst_redirect_pc", redirect_pc, 0);
    check("mid_rst_mispredict_cnt", mispredict_cnt, 0);
    check("mid_rst_branch_cnt", branch_cnt, 0);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_f_ready", 32'(f_ready), 1);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("post_rst_f_ready", 32'(f_ready), 1);

    // Counters restart from zero after reset
    @(negedge clk);
    drive(1, 'h700, 1, 'h740, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 'h740);
    @(posedge clk);
    #1;
    check("post_rst_upd_valid", 32'(upd_valid), 1);
    check("post_rst_upd_pc", upd_pc, 'h700);
    check("post_rst_branch_cnt", branch_cnt, 1);
    check("post_rst_mispredict_cnt", mispredict_cnt, 0);
    check("post_rst_flush", 32'(flush), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    check("post_rst_empty_upd", 32'(upd_valid), 0);
    check("post_rst_empty_err", 32'(err), 1);
    check("post_rst_empty_bcnt", branch_cnt, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
